uart_loopback: RTL and testbench



---
 rtl/uart_loopback_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 82 ++++++++
 rtl/uart_loopback.sv | 120 ++++++++++++
 tb/tb_uart_loopback.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_loopback_pkg.sv
// Shared definitions for the UART echo block: frame constants, FSM state
// encoding and the bit-period helper.
package uart_loopback_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Rounded clocks per serial bit.
    function automatic int clks_per_bit(input int freq, input int baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop input synchronizer, start/data/stop FSM and a
// one-cycle strobe when a byte with a valid stop bit has been captured.
module uart_rx_core
    import uart_loopback_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_ready
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    uart_state_t state, state_next;
    logic          rxd_meta, rxd_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          wait_high;
    logic          cnt_zero;
    logic          load_half, load_full, sample_bit, accept, frame_err;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (rxd_sync == START_BIT && !wait_high) state_next = START;
            START: if (cnt_zero) state_next = (rxd_sync == START_BIT) ? DATA : IDLE;
            DATA:  if (cnt_zero && bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
            STOP:  if (cnt_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_half  = (state == IDLE) && (state_next == START);
        load_full  = ((state == START) && (state_next == DATA)) ||
                     ((state == DATA) && cnt_zero);
        sample_bit = (state == DATA) && cnt_zero;
        accept     = (state == STOP) && cnt_zero && (rxd_sync == STOP_BIT);
        frame_err  = (state == STOP) && cnt_zero && (rxd_sync != STOP_BIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta      <= 1'b1;
            rxd_sync      <= 1'b1;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_data_ready <= 1'b0;
            wait_high     <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            if (load_half)      cnt <= HALF;
            else if (load_full) cnt <= FULL;
            else if (!cnt_zero) cnt <= cnt - CW'(1);
            if (state == START)  bit_idx <= '0;
            else if (sample_bit) bit_idx <= bit_idx + 3'd1;
            if (sample_bit) shreg <= {rxd_sync, shreg[7:1]};
            rx_data_ready <= accept;
            if (accept) rx_data <= shreg;
            // After a framing error the line must return high before a new start is trusted.
            if (frame_err)     wait_high <= 1'b1;
            else if (rxd_sync) wait_high <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_loopback.sv
// UART echo top: receives 8N1 bytes on rxd and retransmits them on txd via a
// one-byte holding register. Define LED_BYTE_COUNT_EN to show a received-byte count on led.
module uart_loopback
    import uart_loopback_pkg::*;
#(
    parameter int CLK_FREQUENCY = 96_000_000,
    parameter int BAUD          = 12_000_000,
    parameter int NUM_LEDS      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rxd,
    output logic                txd,
    output logic                rxd_data_ready,
    output logic [7:0]          rxd_data,
    output logic                txd_busy,
    output logic [NUM_LEDS-1:0] led
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY, BAUD);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_cpb_check
            $error("uart_loopback: CLKS_PER_BIT must be at least 4");
        end
        if (NUM_LEDS < 1 || NUM_LEDS > 8) begin : g_led_check
            $error("uart_loopback: NUM_LEDS must be 1..8");
        end
    endgenerate

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .rx_data       (rxd_data),
        .rx_data_ready (rxd_data_ready)
    );

    uart_state_t tx_state, tx_state_next;
    logic [7:0]    hold_data, tx_shreg;
    logic          hold_full;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit_idx;
    logic          tx_cnt_zero, tx_take;

    assign tx_cnt_zero = (tx_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= IDLE;
        else       tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            IDLE:  if (hold_full) tx_state_next = START;
            START: if (tx_cnt_zero) tx_state_next = DATA;
            DATA:  if (tx_cnt_zero && tx_bit_idx == 3'(DATA_BITS - 1)) tx_state_next = STOP;
            STOP:  if (tx_cnt_zero) tx_state_next = IDLE;
            default: tx_state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_take  = (tx_state == IDLE) && hold_full;
        txd_busy = (tx_state != IDLE);
        case (tx_state)
            START:   txd = START_BIT;
            DATA:    txd = tx_shreg[0];
            default: txd = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            tx_shreg   <= '0;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
        end else begin
            // A new byte wins over both an older held byte and a same-cycle take.
            if (rxd_data_ready) begin
                hold_data <= rxd_data;
                hold_full <= 1'b1;
            end else if (tx_take) begin
                hold_full <= 1'b0;
            end
            if (tx_take) begin
                tx_shreg   <= hold_data;
                tx_cnt     <= FULL;
                tx_bit_idx <= '0;
            end else if (tx_state != IDLE && tx_cnt_zero) begin
                tx_cnt <= FULL;
                if (tx_state == DATA) begin
                    tx_shreg   <= {1'b0, tx_shreg[7:1]};
                    tx_bit_idx <= tx_bit_idx + 3'd1;
                end
            end else if (!tx_cnt_zero) begin
                tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end

`ifdef LED_BYTE_COUNT_EN
    logic [NUM_LEDS-1:0] byte_count;

    always_ff @(posedge clk) begin
        if (reset)               byte_count <= '0;
        else if (rxd_data_ready) byte_count <= byte_count + NUM_LEDS'(1);
    end

    assign led = byte_count;
`else
    assign led = rxd_data[NUM_LEDS-1:0];
`endif

endmodule

// File: tb/tb_uart_loopback.sv
// Directed bench for uart_loopback: serial driver, received-byte scoreboard
// and a txd frame monitor that checks every bit slot cycle by cycle.
module tb_uart_loopback;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       txd;
    logic       rxd_data_ready;
    logic [7:0] rxd_data;
    logic       txd_busy;
    logic [7:0] led;

    uart_loopback #(
        .CLK_FREQUENCY (96_000_000),
        .BAUD          (12_000_000),
        .NUM_LEDS      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rxd            (rxd),
        .txd            (txd),
        .rxd_data_ready (rxd_data_ready),
        .rxd_data       (rxd_data),
        .txd_busy       (txd_busy),
        .led            (led)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  exp_tx_q[$];
    int          passed = 0;
    int          total  = 0;
    int          strobe_count = 0;
    int unsigned strobe_cyc = 0;
    bit          strobe_idle = 1'b0;
    bit          tx_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // driver: one 8N1 frame, CPB cycles per bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            exp_rx_q.push_back(b);
            exp_tx_q.push_back(b);
        end
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            rxd = f[j];
            repeat (CPB - 1) @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (exp_rx_q.size() == 0 && exp_tx_q.size() == 0 && !tx_active && !txd_busy)
                done = 1'b1;
        end
        check("drain_done", {31'b0, done}, 32'd1);
    endtask

    // monitor: received bytes
    always @(negedge clk) begin
        if (!reset && rxd_data_ready) begin
            strobe_count++;
            strobe_cyc  = cyc;
            strobe_idle = !txd_busy;
            if (exp_rx_q.size() == 0) begin
                total++;
                $display("FAIL rx_strobe: unexpected strobe with data 0x%02h, expected none", rxd_data);
            end else begin
                check("rx_data", {24'b0, rxd_data}, {24'b0, exp_rx_q.pop_front()});
            end
        end
    end

    // monitor: transmitted frames
    initial begin
        logic [7:0] e;
        logic [9:0] frame;
        logic [7:0] samp;
        int         busy_cnt;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd === 1'b0) begin
                tx_active = 1'b1;
                if (exp_tx_q.size() == 0) begin
                    total++;
                    $display("FAIL tx_frame: unexpected frame start on txd, expected idle line");
                    repeat (10 * CPB) @(negedge clk);
                end else begin
                    e = exp_tx_q.pop_front();
                    if (strobe_idle)
                        check("tx_latency", cyc - strobe_cyc, 32'd2);
                    frame    = {1'b1, e, 1'b0};
                    busy_cnt = 0;
                    for (int j = 0; j < 10; j++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (j != 0 || c != 0) @(negedge clk);
                            samp[c]  = txd;
                            busy_cnt += int'(txd_busy);
                        end
                        check($sformatf("tx_bit%0d_of_%02h", j, e), {24'b0, samp}, {24'b0, {8{frame[j]}}});
                    end
                    @(negedge clk);
                    check("tx_busy_fall", {31'b0, txd_busy}, 32'd0);
                    check("tx_busy_width", busy_cnt, 32'd80);
                end
                tx_active = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_txd",   {31'b0, txd},            32'd1);
        check("reset_busy",  {31'b0, txd_busy},       32'd0);
        check("reset_ready", {31'b0, rxd_data_ready}, 32'd0);
        check("reset_led",   {24'b0, led},            32'd0);
        @(posedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_txd",   {31'b0, txd},            32'd1);
        check("idle_busy",  {31'b0, txd_busy},       32'd0);
        check("idle_ready", {31'b0, rxd_data_ready}, 32'd0);
        check("idle_led",   {24'b0, led},            32'd0);

        // single byte
        send_frame(8'hAA, 1'b1);
        wait_drain();

        // back-to-back with no idle gap
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        wait_drain();
        check("strobes_after_b2b", strobe_count, 32'd3);
`ifdef LED_BYTE_COUNT_EN
        check("led_after_3", {24'b0, led}, 32'd3);
`else
        check("led_after_3", {24'b0, led}, 32'hBB);
`endif

        // framing error, then a valid byte
        send_frame(8'h55, 1'b0);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("strobes_after_frame_err", strobe_count, 32'd3);
        check("data_held_after_frame_err", {24'b0, rxd_data}, 32'hBB);
        send_frame(8'h3C, 1'b1);
        wait_drain();

        // two-cycle glitch, then a valid byte
        @(posedge clk);
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("strobes_after_glitch", strobe_count, 32'd4);
        send_frame(8'h81, 1'b1);
        wait_drain();

        // bit-width extremes
        send_frame(8'hFF, 1'b1);
        wait_drain();
        send_frame(8'h00, 1'b1);
        wait_drain();

        check("strobes_total", strobe_count, 32'd7);
`ifdef LED_BYTE_COUNT_EN
        check("led_final", {24'b0, led}, 32'd7);
`else
        check("led_final", {24'b0, led}, 32'h00);
`endif
        check("rx_queue_empty", exp_rx_q.size(), 32'd0);
        check("tx_queue_empty", exp_tx_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
